overlap_add_output: RTL and testbench

- Synthesis-side counterpart of the analysis framer. Accepts processed 512-sample frames at hop 256 and overlap-adds them back into one continuous sample stream.
- Applies de-emphasis, y[n] = x[n] + ALPHA*y[n-1] in Q15, which inverts the framer's pre-emphasis high-pass.
- Sits at the end of the frame-domain chain and drives the downstream sample sink, for example the strip/DAC path.

---
 rtl/overlap_add_output.sv | 172 +++++++++++++++++
 tb/tb_overlap_add_output.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlap_add_output.sv
`default_nettype none
// ============================================================================
// Module      : overlap_add_output
// Description : Overlap-adds 512-sample frames at hop 256 into one continuous
//               stream and applies Q15 de-emphasis y[n] = x[n] + ALPHA*y[n-1].
//               The second half of each frame is held in a tail buffer and
//               added to the first half of the next frame. A flush request
//               drains the stored tail at end of stream.
// Revision    : 1.0 - initial release
// ============================================================================
module overlap_add_output #(
   parameter int DATA_W    = 16,
   parameter int FRAME_LEN = 512,
   parameter int HOP       = 256,
   parameter int ALPHA     = 17856
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic signed [DATA_W-1:0] in,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     flush,
   output logic                     flush_busy,
   output logic signed [DATA_W-1:0] out,
   output logic                     m_valid,
   input  logic                     m_ready
);

   localparam int IDX_W   = $clog2(FRAME_LEN);
   localparam int HOP_W   = $clog2(HOP);
   localparam int ACC_W   = 2 * DATA_W;
   localparam int Q_SHIFT = 15;

   localparam logic [IDX_W-1:0] IDX_ZERO       = '0;
   localparam logic [IDX_W-1:0] IDX_HOP        = IDX_W'(HOP);
   localparam logic [IDX_W-1:0] IDX_HOP_LAST   = IDX_W'(HOP - 1);
   localparam logic [IDX_W-1:0] IDX_FRAME_LAST = IDX_W'(FRAME_LEN - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [ACC_W-1:0] ALPHA_S = ACC_W'(ALPHA);

   localparam logic [1:0] ST_ADD   = 2'd0;
   localparam logic [1:0] ST_STORE = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic signed [DATA_W-1:0] y_prev_q, y_prev_d;
   logic signed [DATA_W-1:0] out_q, out_d;
   logic                     m_valid_q, m_valid_d;
   logic signed [DATA_W-1:0] tail_q [HOP];

   logic                     in_xfer;
   logic                     add_load;
   logic                     fl_load;
   logic                     load;
   logic                     flush_start;
   logic signed [DATA_W-1:0] tail_rd;
   logic signed [ACC_W-1:0]  fb;
   logic signed [ACC_W-1:0]  base;
   logic signed [DATA_W-1:0] y_new;

   // Clamp a wide signed value into the DATA_W range.
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)      return DATA_W'(SAT_MAX);
      else if (v < SAT_MIN) return DATA_W'(SAT_MIN);
      else                  return DATA_W'(v);
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_ADD;
      else          state_q <= state_d;
   end

   // Next-state: ADD -> STORE after first half, STORE -> ADD at frame end,
   // ADD -> FLUSH on a frame-aligned flush, FLUSH -> ADD after HOP loads.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ADD: begin
            if (flush_start)                          state_d = ST_FLUSH;
            else if (in_xfer && idx_q == IDX_HOP_LAST) state_d = ST_STORE;
         end
         ST_STORE: begin
            if (in_xfer && idx_q == IDX_FRAME_LAST) state_d = ST_ADD;
         end
         ST_FLUSH: begin
            if (fl_load && idx_q == IDX_HOP_LAST) state_d = ST_ADD;
         end
         default: state_d = ST_ADD;
      endcase
   end

   // State-decoded handshake outputs; a frame-aligned flush blocks input.
   always_comb begin
      s_ready    = 1'b0;
      flush_busy = 1'b0;
      case (state_q)
         ST_ADD:   s_ready = (!m_valid_q || m_ready) && !(flush && idx_q == IDX_ZERO);
         ST_STORE: s_ready = 1'b1;
         ST_FLUSH: flush_busy = 1'b1;
         default: ;
      endcase
   end

   // Overlap-add, de-emphasis and output-register next values.
   always_comb begin
      flush_start = (state_q == ST_ADD) && flush && (idx_q == IDX_ZERO);
      in_xfer     = s_valid && s_ready;
      add_load    = (state_q == ST_ADD) && in_xfer;
      fl_load     = (state_q == ST_FLUSH) && (!m_valid_q || m_ready);
      load        = add_load || fl_load;

      tail_rd = tail_q[HOP_W'(idx_q)];
      fb      = (ALPHA_S * ACC_W'(y_prev_q)) >>> Q_SHIFT;
      if (state_q == ST_FLUSH) base = ACC_W'(tail_rd);
      else                     base = ACC_W'(sat(ACC_W'(in) + ACC_W'(tail_rd)));
      y_new = sat(base + fb);

      idx_d = idx_q;
      if (in_xfer || fl_load) begin
         if (idx_q == IDX_FRAME_LAST || (fl_load && idx_q == IDX_HOP_LAST)) idx_d = IDX_ZERO;
         else                                                              idx_d = idx_q + 1'b1;
      end

      y_prev_d = y_prev_q;
      if (fl_load && idx_q == IDX_HOP_LAST) y_prev_d = '0;
      else if (load)                        y_prev_d = y_new;

      out_d     = out_q;
      m_valid_d = m_valid_q;
      if (load) begin
         out_d     = y_new;
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q     <= IDX_ZERO;
         y_prev_q  <= '0;
         out_q     <= '0;
         m_valid_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         y_prev_q  <= y_prev_d;
         out_q     <= out_d;
         m_valid_q <= m_valid_d;
      end
   end

   // Tail buffer: written in the second half of a frame, cleared as flushed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < HOP; k++) tail_q[k] <= '0;
      end else if (state_q == ST_STORE && in_xfer) begin
         tail_q[HOP_W'(idx_q - IDX_HOP)] <= in;
      end else if (fl_load) begin
         tail_q[HOP_W'(idx_q)] <= '0;
      end
   end

   assign out     = out_q;
   assign m_valid = m_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_overlap_add_output.sv
`default_nettype none
// ============================================================================
// Module      : tb_overlap_add_output
// Description : Scoreboard bench for overlap_add_output. Two instances share
//               the stimulus: one with the default ALPHA, one with ALPHA=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_overlap_add_output;

   localparam int FL      = 512;
   localparam int HP      = 256;
   localparam int ALPHA_A = 17856;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b0;
   logic signed [15:0] in_s   = '0;
   logic              s_valid = 1'b0;
   logic              flush   = 1'b0;
   logic              m_ready = 1'b1;

   logic               s_ready_a, s_ready_0, flush_busy_a, flush_busy_0, m_valid_a, m_valid_0;
   logic signed [15:0] out_a, out_0;

   always #5 clk = ~clk;

   overlap_add_output #(.DATA_W(16), .FRAME_LEN(FL), .HOP(HP), .ALPHA(ALPHA_A)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .in(in_s), .s_valid(s_valid), .s_ready(s_ready_a),
      .flush(flush), .flush_busy(flush_busy_a), .out(out_a), .m_valid(m_valid_a),
      .m_ready(m_ready));

   overlap_add_output #(.DATA_W(16), .FRAME_LEN(FL), .HOP(HP), .ALPHA(0)) u_dut_0 (
      .clk(clk), .reset_n(reset_n), .in(in_s), .s_valid(s_valid), .s_ready(s_ready_0),
      .flush(flush), .flush_busy(flush_busy_0), .out(out_0), .m_valid(m_valid_0),
      .m_ready(m_ready));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_tail [HP];
   int m_yp_a, m_yp_0, m_idx;
   int q_a[$], q_0[$];
   int cap_a [1024];
   int cap_0 [1024];
   int cnt_a, cnt_0;

   function automatic int sat16(input int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int deemph(input int x, input int a, input int yp);
      return sat16(x + ((a * yp) >>> 15));
   endfunction

   task automatic model_reset();
      for (int j = 0; j < HP; j++) m_tail[j] = 0;
      m_yp_a = 0; m_yp_0 = 0; m_idx = 0;
      q_a.delete(); q_0.delete();
      cnt_a = 0; cnt_0 = 0;
   endtask

   task automatic model_input(input int d);
      int s;
      if (m_idx < HP) begin
         s = sat16(d + m_tail[m_idx]);
         m_yp_a = deemph(s, ALPHA_A, m_yp_a); q_a.push_back(m_yp_a);
         m_yp_0 = deemph(s, 0, m_yp_0);       q_0.push_back(m_yp_0);
      end else begin
         m_tail[m_idx - HP] = d;
      end
      m_idx = (m_idx == FL - 1) ? 0 : m_idx + 1;
   endtask

   task automatic model_flush();
      for (int j = 0; j < HP; j++) begin
         m_yp_a = deemph(m_tail[j], ALPHA_A, m_yp_a); q_a.push_back(m_yp_a);
         m_yp_0 = deemph(m_tail[j], 0, m_yp_0);       q_0.push_back(m_yp_0);
         m_tail[j] = 0;
      end
      m_yp_a = 0; m_yp_0 = 0;
   endtask

   // ---------------- monitors ----------------
   initial forever begin
      @(negedge clk); #2;
      if (reset_n && m_valid_a && m_ready) begin
         if (q_a.size() == 0) check_val("sb_a_extra", 1, 0);
         else                 check_val("sb_a", out_a, q_a.pop_front());
         if (cnt_a < 1024) cap_a[cnt_a] = out_a;
         cnt_a++;
      end
   end

   initial forever begin
      @(negedge clk); #2;
      if (reset_n && m_valid_0 && m_ready) begin
         if (q_0.size() == 0) check_val("sb_0_extra", 1, 0);
         else                 check_val("sb_0", out_0, q_0.pop_front());
         if (cnt_0 < 1024) cap_0[cnt_0] = out_0;
         cnt_0++;
      end
   end

   // ---------------- drivers ----------------
   task automatic drive_cycle(input logic v, input int d, input logic mr, input logic fl,
                              output logic acc);
      @(negedge clk);
      s_valid = v; in_s = 16'(d); m_ready = mr; flush = fl;
      #1;
      acc = v && s_ready_0;
      if (acc) model_input(d);
      if (fl && m_idx == 0) model_flush();
   endtask

   task automatic send_sample(input int d, input logic mr, output int tries);
      logic acc;
      tries = 0;
      do begin
         drive_cycle(1'b1, d, mr, 1'b0, acc);
         tries++;
      end while (!acc && tries < 200);
      if (!acc) check_val("send_timeout", 0, 1);
   endtask

   task automatic send_n(input int n, input int d, output int stalls);
      int t;
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         send_sample(d, 1'b1, t);
         if (t > 1) stalls++;
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 1'b1, 1'b0, acc);
   endtask

   task automatic drain();
      int tries = 0;
      while ((q_a.size() != 0 || q_0.size() != 0) && tries < 3000) begin
         idle(1);
         tries++;
      end
      if (q_a.size() != 0 || q_0.size() != 0) check_val("drain_timeout", q_a.size() + q_0.size(), 0);
      idle(2);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b1;
      model_reset();
      #1;
      check_val({tag, "_mvalid"}, m_valid_0, 0);
      check_val({tag, "_out"}, out_0, 0);
      check_val({tag, "_sready"}, s_ready_0, 1);
      check_val({tag, "_fbusy"}, flush_busy_0, 0);
      check_val({tag, "_mvalid_a"}, m_valid_a, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   initial begin
      int   st, t, busy, tries;
      logic acc;

      // 1: impulse through de-emphasis
      do_reset("rst1");
      send_sample(16384, 1'b1, t);
      send_n(FL - 1, 0, st);
      drain();
      check_val("t1_y0", cap_a[0], 16384);
      check_val("t1_y1", cap_a[1], 8928);
      check_val("t1_y2", cap_a[2], 4865);
      check_val("t1_count", cnt_a, 256);
      for (int i = 1; i < HP; i++) check_val("t1_decay", int'(cap_a[i] <= cap_a[i-1]), 1);

      // 2: overlap-add at full rate
      do_reset("rst2");
      send_n(FL, 100, st);
      send_n(FL, 200, t);
      drain();
      check_val("t2_stalls", st + t, 0);
      check_val("t2_count", cnt_0, 512);
      check_val("t2_first", cap_0[0], 100);
      check_val("t2_half", cap_0[255], 100);
      check_val("t2_ovl", cap_0[256], 300);
      check_val("t2_last", cap_0[511], 300);

      // 3: saturation in both directions
      do_reset("rst3p");
      send_n(2 * FL, 30000, st);
      drain();
      check_val("t3_pos_first", cap_0[0], 30000);
      check_val("t3_pos_sat", cap_0[256], 32767);
      do_reset("rst3n");
      send_n(2 * FL, -30000, st);
      drain();
      check_val("t3_neg_sat", cap_0[256], -32768);
      check_val("t3_neg_last", cap_0[511], -32768);

      // 4: backpressure in ADD, STORE ignores output side
      do_reset("rst4");
      send_n(100, 5, st);
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 5, 1'b0, 1'b0, acc);
         check_val("t4_bp_sready", acc, 0);
         check_val("t4_bp_mvalid", m_valid_0, 1);
         check_val("t4_bp_out", out_0, 5);
      end
      send_n(HP - 100, 5, st);
      for (int i = 0; i < HP; i++) begin
         send_sample(5, 1'b0, t);
         check_val("t4_store_sready", t, 1);
      end
      drain();
      check_val("t4_count", cnt_0, 256);

      // 5: flush drains the tail and clears it
      do_reset("rst5");
      send_n(FL, 100, st);
      drain();
      cnt_0 = 0; cnt_a = 0;
      drive_cycle(1'b1, 55, 1'b1, 1'b1, acc);
      check_val("t5_flush_wins", acc, 0);
      busy = 0; tries = 0;
      do begin
         drive_cycle(1'b0, 0, 1'b1, 1'b0, acc);
         tries++;
         if (flush_busy_0) begin
            busy++;
            check_val("t5_sready_busy", s_ready_0, 0);
         end
      end while (flush_busy_0 && tries < 2000);
      check_val("t5_busy_cycles", busy, 256);
      drain();
      check_val("t5_count", cnt_0, 256);
      check_val("t5_val", cap_0[0], 100);
      send_n(FL, 7, st);
      drain();
      check_val("t5_after_first", cap_0[256], 7);
      check_val("t5_after_last", cap_0[511], 7);

      // 6: reset mid-STORE discards the tail
      do_reset("rst6a");
      send_n(300, 9, st);
      do_reset("rst6b");
      send_n(FL, 50, st);
      drain();
      check_val("t6_first", cap_0[0], 50);
      check_val("t6_last", cap_0[255], 50);
      check_val("t6_count", cnt_0, 256);

      check_val("end_q_a", q_a.size(), 0);
      check_val("end_q_0", q_0.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #5000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
`default_nettype wire
